// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: next-PC select encodings (shared with the
// decode controller), default reset PC and fetch FSM states.
package fetch_unit_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BEQ = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection: sequential, branch-if-equal, jump and jump-register.
import fetch_unit_pkg::*;

module npc_calc (
  input  logic [31:0] pc,
  input  logic [25:0] instr,
  input  logic [1:0]  npcop,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] npc,
  output logic        jr_misalign
);

  logic [31:0] p4;
  logic [31:0] br_off;

  assign p4     = pc + 32'd4;
  assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    npc         = p4;
    jr_misalign = 1'b0;
    case (npcop)
      NPC_SEQ: npc = p4;
      NPC_BEQ: npc = zero ? (p4 + br_off) : p4;
      NPC_J:   npc = {p4[31:28], instr[25:0], 2'b00};
      NPC_JR: begin
        npc         = {rs_data[31:2], 2'b00};
        jr_misalign = (rs_data[1:0] != 2'b00);
      end
      default: npc = p4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds PC/IR, fetches over a req/ack memory port and
// issues to decode through a valid/ready handshake.
import fetch_unit_pkg::*;

module fetch_unit #(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  npcop,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign
);

  state_t      state, state_nxt;
  logic [31:0] npc;
  logic        jr_misalign;

  npc_calc u_npc_calc (
    .pc          (pc),
    .instr       (instr[25:0]),
    .npcop       (npcop),
    .zero        (zero),
    .rs_data     (rs_data),
    .npc         (npc),
    .jr_misalign (jr_misalign)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (imem_ack)    state_nxt = ISSUE;
      ISSUE:   if (instr_ready) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      FETCH:   imem_req    = 1'b1;
      ISSUE:   instr_valid = 1'b1;
      default: imem_req    = 1'b0;
    endcase
  end

  // Reset clears IR too, so an ack arriving alongside reset can never load it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= PC_RESET;
      instr    <= '0;
      misalign <= 1'b0;
    end else begin
      if (state == FETCH && imem_ack)
        instr <= imem_rdata;
      if (state == ISSUE && instr_ready) begin
        pc <= npc;
        if (jr_misalign)
          misalign <= 1'b1;
      end
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign pc_plus4  = pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: a table of single-instruction
// fetch/issue/retire vectors plus hand-written stall and reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  npcop;
  logic        zero;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_RESET(32'h0000_3000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .npcop       (npcop),
    .zero        (zero),
    .rs_data     (rs_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .misalign    (misalign)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  op_sel;
    logic        z;
    logic [31:0] rs;
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
    logic [5:0]  exp_op;
    logic [5:0]  exp_fn;
    logic [31:0] exp_next;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},   {31'd0, imem_req},    32'd1);
    check({tag, "_addr"},  imem_addr,            32'h0000_3000);
    check({tag, "_pc"},    pc,                   32'h0000_3000);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr,                32'd0);
    check({tag, "_mis"},   {31'd0, misalign},    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h3C01_1234, 2'b00, 1'b0, 32'h0,         32'h0000_3000, 32'h0000_3004, 6'h0F, 6'h34, 32'h0000_3004, 1'b0};
    vecs[1] = '{32'h0800_0C04, 2'b10, 1'b0, 32'h0,         32'h0000_3004, 32'h0000_3008, 6'h02, 6'h04, 32'h0000_3010, 1'b0};
    vecs[2] = '{32'h1000_FFFF, 2'b01, 1'b1, 32'h0,         32'h0000_3010, 32'h0000_3014, 6'h04, 6'h3F, 32'h0000_3010, 1'b0};
    vecs[3] = '{32'h1000_FFFF, 2'b01, 1'b0, 32'h0,         32'h0000_3010, 32'h0000_3014, 6'h04, 6'h3F, 32'h0000_3014, 1'b0};
    vecs[4] = '{32'h03E0_0008, 2'b11, 1'b0, 32'h0000_3022, 32'h0000_3014, 32'h0000_3018, 6'h00, 6'h08, 32'h0000_3020, 1'b1};
    vecs[5] = '{32'h03E0_0008, 2'b11, 1'b0, 32'hFFFF_FFFC, 32'h0000_3020, 32'h0000_3024, 6'h00, 6'h08, 32'hFFFF_FFFC, 1'b1};
    vecs[6] = '{32'h0000_0000, 2'b00, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 6'h00, 6'h00, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'h0800_0C00, 2'b10, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004, 6'h02, 6'h00, 32'h0000_3000, 1'b1};
    vecs[8] = '{32'h0C00_0C05, 2'b10, 1'b0, 32'h0,         32'h0000_3000, 32'h0000_3004, 6'h03, 6'h05, 32'h0000_3014, 1'b1};

    imem_rdata = '0;
    npcop      = 2'b00;
    zero       = 1'b0;
    rs_data    = '0;
    do_reset();
    check_reset_state("rst0");

    // Delayed ack: request and address stay put for 4 cycles, then stall in ISSUE.
    for (int i = 0; i < 3; i++) begin
      check("dly_req",  {31'd0, imem_req},    32'd1);
      check("dly_addr", imem_addr,            32'h0000_3000);
      check("dly_vld",  {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
    end
    check("dly_req4",  {31'd0, imem_req}, 32'd1);
    check("dly_addr4", imem_addr,         32'h0000_3000);
    imem_ack   = 1'b1;
    imem_rdata = 32'h3C01_1234;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("stall_vld",   {31'd0, instr_valid}, 32'd1);
      check("stall_req",   {31'd0, imem_req},    32'd0);
      check("stall_instr", instr,                32'h3C01_1234);
      check("stall_pc",    pc,                   32'h0000_3000);
      // an ack while issuing must not disturb IR
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ack = 1'b0;
    end
    check("stall_instr_after", instr, 32'h3C01_1234);
    instr_ready = 1'b1;
    npcop       = 2'b00;
    @(negedge clk);
    instr_ready = 1'b0;
    check("stall_next", imem_addr, 32'h0000_3004);

    do_reset();
    check_reset_state("rst1");

    foreach (vecs[k]) begin
      check("v_req",  {31'd0, imem_req}, 32'd1);
      check("v_addr", imem_addr,         vecs[k].exp_pc);
      imem_ack   = 1'b1;
      imem_rdata = vecs[k].rdata;
      @(negedge clk);
      imem_ack = 1'b0;
      check("v_valid",  {31'd0, instr_valid}, 32'd1);
      check("v_instr",  instr,                vecs[k].rdata);
      check("v_pc",     pc,                   vecs[k].exp_pc);
      check("v_p4",     pc_plus4,             vecs[k].exp_p4);
      check("v_opcode", {26'd0, opcode},      {26'd0, vecs[k].exp_op});
      check("v_funct",  {26'd0, funct},       {26'd0, vecs[k].exp_fn});
      npcop       = vecs[k].op_sel;
      zero        = vecs[k].z;
      rs_data     = vecs[k].rs;
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      npcop       = 2'b00;
      zero        = 1'b0;
      rs_data     = '0;
      check("v_next",  imem_addr,            vecs[k].exp_next);
      check("v_fetch", {31'd0, instr_valid}, 32'd0);
      check("v_mis",   {31'd0, misalign},    {31'd0, vecs[k].exp_mis});
    end

    // Reset with a late ack in FETCH: IR must not load, no stale issue.
    @(negedge clk);
    @(negedge clk);
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    check_reset_state("rstF");
    @(negedge clk);
    check("rstF_vld2", {31'd0, instr_valid}, 32'd0);
    check("rstF_req2", {31'd0, imem_req},    32'd1);

    // Reset in ISSUE together with instr_ready and a misaligned jr.
    imem_ack   = 1'b1;
    imem_rdata = 32'h03E0_0008;
    @(negedge clk);
    imem_ack = 1'b0;
    check("rstI_vld", {31'd0, instr_valid}, 32'd1);
    rst_n       = 1'b0;
    instr_ready = 1'b1;
    npcop       = 2'b11;
    rs_data     = 32'h0000_3023;
    @(negedge clk);
    rst_n       = 1'b1;
    instr_ready = 1'b0;
    npcop       = 2'b00;
    rs_data     = '0;
    check_reset_state("rstI");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
